clip_timer: RTL and testbench

- Timing/address stage directly downstream of the record/play controller.
- Consumes the controller's enableTimer and clipNum.
- Paces sample transfers at a fixed sample rate and produces the running sample-memory address for the selected clip.
- Returns the one-cycle secondMarker pulse that sends the controller back to standby when the clip length has elapsed.

---
 rtl/clip_timer.sv | 175 +++++++++++++++++
 tb/tb_clip_timer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clip_timer.sv
// ---------------------------------------------------------------------------
// clip_timer
//
// This is the timing and address stage that sits after the record/play
// controller. While enableTimer is held, it emits a sampleStrobe once every
// CYCLES_PER_SAMPLE clocks. Each strobe carries the running sample-memory
// address for the selected clip. On the last sample of the clip it also
// raises the one-cycle secondMarker pulse, which sends the controller back
// to standby.
//
// Optional feature (macro CLIP_TIMER_ELAPSED_EN):
//   secondTick      one-cycle pulse on every SAMPLES_PER_SEC-th strobe of a run
//   secondsElapsed  count of secondTick pulses, saturating at 15
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   enableTimer   in   level run request from the controller
//   clipNum       in   clip select (0/1), latched when a run starts
//   sampleStrobe  out  one-cycle pulse: transfer one sample at sampleAddr
//   sampleAddr    out  sample memory address, valid while sampleStrobe=1
//   secondMarker  out  one-cycle pulse: clip length elapsed
//   busy          out  high while in RUN
//   stateDbg      out  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: enableTimer is a level request with no acknowledge.
// sampleStrobe is a one-cycle qualifier for sampleAddr with no backpressure;
// the consumer must take the sample in the cycle it is strobed. Both pulses
// are gated by enableTimer in the same cycle, so dropping the enable
// suppresses any strobe or marker that would have fired in that cycle.
// ---------------------------------------------------------------------------
module clip_timer #(
  parameter int CYCLES_PER_SAMPLE = 6250,
  parameter int SAMPLES_PER_SEC   = 8000,
  parameter int CLIP_SECONDS      = 4,
  parameter int ADDR_W            = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enableTimer,
  input  logic              clipNum,
  output logic              sampleStrobe,
  output logic [ADDR_W-1:0] sampleAddr,
  output logic              secondMarker,
  output logic              busy,
`ifdef CLIP_TIMER_ELAPSED_EN
  output logic              secondTick,
  output logic [3:0]        secondsElapsed,
`endif
  output logic [1:0]        stateDbg
);

  localparam int CLIP_LEN = SAMPLES_PER_SEC * CLIP_SECONDS;
  localparam int PRE_W    = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CYCLES_PER_SAMPLE - 1);
  localparam logic [ADDR_W-1:0] OFF_LAST  = ADDR_W'(CLIP_LEN - 1);
  localparam logic [ADDR_W-1:0] CLIP_BASE = ADDR_W'(CLIP_LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        nextState;
  logic [PRE_W-1:0]  prescaler;
  logic [PRE_W-1:0]  preNext;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] offNext;
  logic              latchedClip;
  logic              clipNext;
  logic              strobeNow;
  logic              lastSample;
  logic              loadAddr;
  logic [ADDR_W-1:0] addrNext;

  // A strobe fires on the last prescaler count. It is gated by the live
  // enable, so an abort in the same cycle wins over the strobe.
  assign strobeNow    = (state == S_RUN) && enableTimer && (prescaler == PRE_LAST);
  assign lastSample   = (offset == OFF_LAST);
  assign sampleStrobe = strobeNow;
  assign secondMarker = strobeNow && lastSample;
  assign busy         = (state == S_RUN);
  assign stateDbg     = state;

  always_comb begin
    nextState = state;
    preNext   = prescaler;
    offNext   = offset;
    clipNext  = latchedClip;
    case (state)
      S_IDLE: begin
        if (enableTimer) begin
          nextState = S_RUN;
          preNext   = '0;
          offNext   = '0;
          clipNext  = clipNum;
        end
      end
      S_RUN: begin
        if (!enableTimer) begin
          nextState = S_IDLE;
        end else begin
          preNext = (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
          if (strobeNow) begin
            if (lastSample) begin
              nextState = S_DONE;
            end else begin
              offNext = offset + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (!enableTimer) begin
          nextState = S_IDLE;
        end
      end
      default: nextState = S_IDLE;
    endcase
  end

  // sampleAddr is registered one cycle ahead of the strobe: it is loaded on
  // the edge where the prescaler reaches its last count. This puts the
  // address in a flop in the strobe cycle and leaves it untouched in IDLE
  // and DONE. The sum stays below 2*CLIP_LEN, so it never wraps.
  assign loadAddr = (nextState == S_RUN) && (preNext == PRE_LAST);
  assign addrNext = (clipNext ? CLIP_BASE : '0) + offNext;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      prescaler   <= '0;
      offset      <= '0;
      latchedClip <= 1'b0;
      sampleAddr  <= '0;
    end else begin
      state       <= nextState;
      prescaler   <= preNext;
      offset      <= offNext;
      latchedClip <= clipNext;
      if (loadAddr) begin
        sampleAddr <= addrNext;
      end
    end
  end

`ifdef CLIP_TIMER_ELAPSED_EN
  localparam int SEC_W = (SAMPLES_PER_SEC > 1) ? $clog2(SAMPLES_PER_SEC) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SAMPLES_PER_SEC - 1);

  logic [SEC_W-1:0] secCount;
  logic             tickNow;

  // secCount counts strobes within the current second of the run.
  assign tickNow    = strobeNow && (secCount == SEC_LAST);
  assign secondTick = tickNow;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      secCount       <= '0;
      secondsElapsed <= 4'd0;
    end else if ((state == S_IDLE) && enableTimer) begin
      secCount       <= '0;
      secondsElapsed <= 4'd0;
    end else if (strobeNow) begin
      secCount <= tickNow ? '0 : secCount + 1'b1;
      if (tickNow && (secondsElapsed != 4'hF)) begin
        secondsElapsed <= secondsElapsed + 4'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_clip_timer.sv
// ---------------------------------------------------------------------------
// tb_clip_timer
//
// Self-checking bench for clip_timer. It uses a small configuration:
// CYCLES_PER_SAMPLE=4, SAMPLES_PER_SEC=3, CLIP_SECONDS=2 (CLIP_LEN=6),
// ADDR_W=4. Each scenario task pushes the strobes it expects into exp_q.
// A negedge monitor pops and compares every strobe the DUT produces.
// ---------------------------------------------------------------------------
module tb_clip_timer;

  localparam int CPS      = 4;
  localparam int SPS      = 3;
  localparam int CSEC     = 2;
  localparam int ADDR_W   = 4;
  localparam int CLIP_LEN = SPS * CSEC;
  localparam int W        = ADDR_W + 2;  // {tick, marker, addr}

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              enableTimer = 1'b0;
  logic              clipNum = 1'b0;
  logic              sampleStrobe;
  logic [ADDR_W-1:0] sampleAddr;
  logic              secondMarker;
  logic              busy;
  logic [1:0]        stateDbg;
  logic              tickObs;
`ifdef CLIP_TIMER_ELAPSED_EN
  logic              secondTick;
  logic [3:0]        secondsElapsed;
  assign tickObs = secondTick;
`else
  assign tickObs = 1'b0;
`endif

  always #5 clock = ~clock;

  int cycleCount = 0;
  always @(posedge clock) cycleCount++;

  clip_timer #(
    .CYCLES_PER_SAMPLE(CPS),
    .SAMPLES_PER_SEC  (SPS),
    .CLIP_SECONDS     (CSEC),
    .ADDR_W           (ADDR_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enableTimer   (enableTimer),
    .clipNum       (clipNum),
    .sampleStrobe  (sampleStrobe),
    .sampleAddr    (sampleAddr),
    .secondMarker  (secondMarker),
    .busy          (busy),
`ifdef CLIP_TIMER_ELAPSED_EN
    .secondTick    (secondTick),
    .secondsElapsed(secondsElapsed),
`endif
    .stateDbg      (stateDbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int fails  = 0;
  int lastStrobe = -1;
  logic prevStrobe = 1'b0;
  logic prevMarker = 1'b0;

  always @(negedge clock) begin
    logic [W-1:0] expv;
    logic [W-1:0] obs;
    // Pulses must be isolated, and a marker may only ride on a strobe.
    checks++;
    if ((sampleStrobe && prevStrobe) || (secondMarker && prevMarker) ||
        (secondMarker && !sampleStrobe)) begin
      fails++;
      $display("FAIL pulse_shape: strobe=%0b marker=%0b prevStrobe=%0b prevMarker=%0b, required isolated pulses with marker only on a strobe",
               sampleStrobe, secondMarker, prevStrobe, prevMarker);
    end
    prevStrobe = sampleStrobe;
    prevMarker = secondMarker;
    if (sampleStrobe) begin
      obs = {tickObs, secondMarker, sampleAddr};
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: tick/marker/addr=%0b/%0b/%0d, required no strobe",
                 tickObs, secondMarker, sampleAddr);
      end else begin
        expv = exp_q.pop_front();
        if (obs !== expv) begin
          fails++;
          $display("FAIL strobe_data: tick/marker/addr=%0b/%0b/%0d, required %0b/%0b/%0d",
                   obs[W-1], obs[W-2], obs[ADDR_W-1:0], expv[W-1], expv[W-2], expv[ADDR_W-1:0]);
        end
      end
      if (lastStrobe >= 0) begin
        checks++;
        if (cycleCount - lastStrobe != CPS) begin
          fails++;
          $display("FAIL strobe_period: gap=%0d, required %0d", cycleCount - lastStrobe, CPS);
        end
      end
      lastStrobe = cycleCount;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  // Queue the first n strobes of a run for the given clip.
  task automatic push_run(input int clip, input int n);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] e;
      e[ADDR_W-1:0] = ADDR_W'(clip * CLIP_LEN + i);
      e[W-2]        = (i == CLIP_LEN - 1);
`ifdef CLIP_TIMER_ELAPSED_EN
      e[W-1]        = ((i % SPS) == SPS - 1);
`else
      e[W-1]        = 1'b0;
`endif
      exp_q.push_back(e);
    end
  endtask

  // Waits (bounded) for n strobes; returns on the negedge of the last one.
  task automatic wait_strobes(input int n, input int budget, output int got);
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clock);
      if (sampleStrobe) got++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    enableTimer = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({sampleStrobe, sampleAddr, secondMarker, busy, stateDbg} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: strobe=%0b addr=%0d marker=%0b busy=%0b state=%0d, required all 0",
               sampleStrobe, sampleAddr, secondMarker, busy, stateDbg);
    end
    drive_edge();
    reset = 1'b1;
    drive_edge();
  endtask

  task automatic test_full_run(input int clip, input bit toggleClip);
    int got;
    int start;
    lastStrobe = -1;
    push_run(clip, CLIP_LEN);
    clipNum = clip[0];
    enableTimer = 1'b1;
    start = cycleCount;
    wait_strobes(1, 4 * CPS, got);
    checks++;
    if (got != 1 || cycleCount - start != CPS) begin
      fails++;
      $display("FAIL first_strobe_latency: got=%0d cycles=%0d, required 1 strobe after %0d", got, cycleCount - start, CPS);
    end
    if (toggleClip) begin
      drive_edge();
      clipNum = ~clipNum;
    end
    wait_strobes(CLIP_LEN - 1, CLIP_LEN * CPS + 10, got);
    checks++;
    if (got != CLIP_LEN - 1 || !secondMarker || !busy) begin
      fails++;
      $display("FAIL run_end: strobes=%0d marker=%0b busy=%0b, required %0d/1/1", got, secondMarker, busy, CLIP_LEN - 1);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || stateDbg !== ST_DONE) begin
      fails++;
      $display("FAIL done_entry: busy=%0b state=%0d, required 0/%0d", busy, stateDbg, ST_DONE);
    end
  endtask

  task automatic test_done_hold();
    int got;
    wait_strobes(1, 20, got);
    checks++;
    if (got != 0 || stateDbg !== ST_DONE || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_hold: strobes=%0d state=%0d busy=%0b, required 0/%0d/0", got, stateDbg, busy, ST_DONE);
    end
`ifdef CLIP_TIMER_ELAPSED_EN
    checks++;
    if (secondsElapsed !== 4'd2) begin
      fails++;
      $display("FAIL seconds_elapsed: got=%0d, required 2", secondsElapsed);
    end
`endif
    drive_edge();
    enableTimer = 1'b0;
    drive_edge();
    checks++;
    if (stateDbg !== ST_IDLE) begin
      fails++;
      $display("FAIL done_release: state=%0d, required %0d", stateDbg, ST_IDLE);
    end
  endtask

  task automatic test_abort();
    int got;
    drive_edge();
    lastStrobe = -1;
    push_run(0, 3);
    clipNum = 1'b0;
    enableTimer = 1'b1;
    wait_strobes(3, 4 * CPS + 10, got);
    drive_edge();
    enableTimer = 1'b0;
    wait_strobes(1, 3 * CPS, got);
    checks++;
    if (got != 0 || stateDbg !== ST_IDLE || busy !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL abort: strobes=%0d state=%0d busy=%0b pending=%0d, required 0/%0d/0/0",
               got, stateDbg, busy, exp_q.size(), ST_IDLE);
    end
  endtask

  // Drop the enable exactly in the cycle that would carry the final strobe.
  task automatic test_abort_on_final();
    int got;
    drive_edge();
    lastStrobe = -1;
    push_run(1, CLIP_LEN - 1);
    clipNum = 1'b1;
    enableTimer = 1'b1;
    wait_strobes(CLIP_LEN - 1, CLIP_LEN * CPS + 10, got);
    repeat (CPS) @(posedge clock);
    #1;
    enableTimer = 1'b0;
    @(negedge clock);
    checks++;
    if (sampleStrobe !== 1'b0 || secondMarker !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_final: strobe=%0b marker=%0b busy=%0b, required 0/0/1", sampleStrobe, secondMarker, busy);
    end
    @(negedge clock);
    checks++;
    if (stateDbg !== ST_IDLE) begin
      fails++;
      $display("FAIL abort_final_state: state=%0d, required %0d", stateDbg, ST_IDLE);
    end
  endtask

  task automatic test_reset_mid_run();
    int got;
    int start;
    drive_edge();
    lastStrobe = -1;
    push_run(0, 2);
    clipNum = 1'b0;
    enableTimer = 1'b1;
    wait_strobes(2, 3 * CPS + 10, got);
    drive_edge();
    reset = 1'b0;
    #1;
    checks++;
    if ({sampleStrobe, sampleAddr, secondMarker, busy, stateDbg} !== '0) begin
      fails++;
      $display("FAIL reset_mid_run: strobe=%0b addr=%0d marker=%0b busy=%0b state=%0d, required all 0",
               sampleStrobe, sampleAddr, secondMarker, busy, stateDbg);
    end
    repeat (2) drive_edge();
    lastStrobe = -1;
    push_run(0, CLIP_LEN);
    reset = 1'b1;
    start = cycleCount;
    wait_strobes(1, 4 * CPS, got);
    checks++;
    if (got != 1 || cycleCount - start != CPS) begin
      fails++;
      $display("FAIL reset_restart_latency: got=%0d cycles=%0d, required 1 strobe after %0d", got, cycleCount - start, CPS);
    end
    wait_strobes(CLIP_LEN - 1, CLIP_LEN * CPS + 10, got);
    checks++;
    if (got != CLIP_LEN - 1 || !secondMarker) begin
      fails++;
      $display("FAIL reset_restart_run: strobes=%0d marker=%0b, required %0d/1", got, secondMarker, CLIP_LEN - 1);
    end
    drive_edge();
    enableTimer = 1'b0;
    drive_edge();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    test_reset();
    test_full_run(0, 1'b0);
    test_done_hold();
    drive_edge();
    test_full_run(1, 1'b1);
    test_done_hold();
    test_abort();
    test_abort_on_final();
    drive_edge();
    test_full_run(0, 1'b0);
    drive_edge();
    enableTimer = 1'b0;
    drive_edge();
    test_reset_mid_run();
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expected: pending=%0d, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

endmodule
